qsn_ctrl_85b: RTL and testbench
===============================

// Module: qsn_ctrl_85b
// PURPOSE
//   Control generator sitting directly upstream of the 85-bit QSN cyclic-shift network.
//   Converts a stream of circulant shift factors into registered left_sel/right_sel/merge_sel words.
//   Supports both forward and inverse permutation.
//   Tracks column and layer position inside the layered LDPC decoder schedule.
//   Two-stage valid/ready pipeline; full throughput of one shift factor per cycle.
// PARAMETERS
//   Z        85   circulant size (QSN width)
//   SEL_W    7    shift-select width, ceil(log2(Z))
//   COL_NUM  8    circulant columns per layer (max col_idx+1)
//   COL_W    3    width of col_idx, ceil(log2(COL_NUM))
//   LAYER_W  4    width of layer_cnt
// PORTS
//   sys_clk       in   1        system clock, all logic rising-edge
//   rst           in   1        synchronous reset, active-high
//   shift_valid   in   1        upstream shift factor valid
//   shift_ready   out  1        block can accept shift factor this cycle
//   shift_factor  in   SEL_W    circulant shift s, legal range 0..Z-1
//   shift_inv     in   1        1 = inverse permutation (use (Z-s) mod Z)
//   shift_last    in   1        marks last column of current layer
//   sel_valid     out  1        select words valid toward QSN / datapath
//   sel_ready     in   1        downstream accepts select words
//   left_sel      out  SEL_W    left-network shift amount
//   right_sel     out  SEL_W    right-network shift amount
//   merge_sel     out  Z-1      merge select, bit i=1 -> sw_out[i] from left network
//   col_idx       out  COL_W    column index of the current output within its layer
//   layer_end     out  1        current output is last column of its layer
//   layer_cnt     out  LAYER_W  completed-layer counter, wraps at 2^LAYER_W
//   err_range     out  1        sticky: an out-of-range shift_factor was accepted
// BEHAVIOUR
//   Reset: all outputs 0, both pipeline stages empty; shift_ready is 1 in the cycle after reset deasserts.
//   Handshake: transfer on valid&&ready at the rising edge.
//     Once sel_valid is high, it holds with stable data until sel_ready.
//     shift_ready = !s1_full || s1_advance, where s1_advance = !s2_full || sel_ready.
//     The combinational path sel_ready->shift_ready is permitted.
//   Stage 1 (registered): effective shift e and range flag.
//     If shift_factor >= Z: e = 0 and err_range is set (sticky until rst). Otherwise e = shift_factor.
//     If shift_inv = 1: e = (e==0) ? 0 : Z-e.
//     Stage 1 also registers shift_last.
//   Stage 2 (registered, drives outputs):
//     left_sel = e.
//     right_sel = (e==0) ? 0 : Z-e.
//     merge_sel[i] = (i < Z-e) for i in 0..Z-2, so e=0 gives all ones.
//   Latency: 2 cycles from input handshake to sel_valid when there is no backpressure; throughput 1/cycle.
//   Counters update on output handshake (sel_valid && sel_ready):
//     col_idx increments. On layer_end it resets to 0 and layer_cnt increments (wraps).
//     If col_idx reaches COL_NUM-1 without shift_last, the next column wraps to 0 without a layer_cnt increment.
//     In that case err_range is also set.
//   col_idx/layer_end describe the word currently on the outputs. col_idx is 0 after reset.
//   Simultaneous: an input and an output handshake in the same cycle are both honoured, with no bubble.
//   rst mid-operation flushes both stages and clears the counters and err_range. Data in flight is discarded.
// TESTING
//   1. Reset, then s=0, inv=0, sel_ready=1 -> 2 cycles later: left=0, right=0, merge_sel=all ones, sel_valid=1.
//   2. s=10, inv=0 -> left=10, right=75, merge_sel[74:0]=1, merge_sel[83:75]=0.
//      s=10, inv=1 -> left=75, right=10, merge_sel[9:0]=1, remaining bits 0.
//   3. Burst s=1..8 with shift_last on the 8th, sel_ready=1 every cycle:
//      8 consecutive sel_valid cycles, col_idx 0..7, layer_end on col 7, then layer_cnt=1.
//   4. Same burst with sel_ready toggling 1,0,0,1:
//      no word lost or duplicated, outputs stable while stalled, shift_ready drops only when both stages are full.
//   5. s=85 and s=127 -> e=0 outputs (left=0, merge all ones), err_range=1 and stays 1 until rst.
//   6. Assert rst with both stages full -> next cycle sel_valid=0, col_idx=0, layer_cnt=0, err_range=0.
//      The following input then emerges 2 cycles after its handshake.

Source files
------------

// File: rtl/qsn_ctrl_85b.sv
// Select-word generator for the 85-bit QSN cyclic-shift network.
// Two-stage valid/ready pipeline: effective shift, then left/right/merge selects plus schedule position.
module qsn_ctrl_85b #(
   parameter int unsigned Z       = 85,
   parameter int unsigned SEL_W   = 7,
   parameter int unsigned COL_NUM = 8,
   parameter int unsigned COL_W   = 3,
   parameter int unsigned LAYER_W = 4
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               shift_valid,
   output logic               shift_ready,
   input  logic [SEL_W-1:0]   shift_factor,
   input  logic               shift_inv,
   input  logic               shift_last,
   output logic               sel_valid,
   input  logic               sel_ready,
   output logic [SEL_W-1:0]   left_sel,
   output logic [SEL_W-1:0]   right_sel,
   output logic [Z-2:0]       merge_sel,
   output logic [COL_W-1:0]   col_idx,
   output logic               layer_end,
   output logic [LAYER_W-1:0] layer_cnt,
   output logic               err_range
);

   localparam logic [SEL_W-1:0] ZS       = SEL_W'(Z);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_NUM - 1);

   logic               s1_full_q, s1_full_d;
   logic [SEL_W-1:0]   s1_e_q, s1_e_d;
   logic               s1_last_q;
   logic               s2_full_q, s2_full_d;
   logic [SEL_W-1:0]   left_q, right_q, right_d;
   logic [Z-2:0]       merge_q, merge_d;
   logic               layer_end_q;
   logic [COL_W-1:0]   col_q, col_d;
   logic [LAYER_W-1:0] layer_q, layer_d;
   logic               err_q, err_d;

   logic               in_fire, out_fire, s1_advance, s1_move, in_range;
   logic [SEL_W-1:0]   e_raw;
   int unsigned        merge_lim;

   // Handshake: sel_ready feeds shift_ready combinationally so a full pipe can still stream.
   always_comb begin
      s1_advance  = !s2_full_q || sel_ready;
      shift_ready = !s1_full_q || s1_advance;
      in_fire     = shift_valid && shift_ready;
      out_fire    = s2_full_q && sel_ready;
      s1_move     = s1_full_q && s1_advance;
      s1_full_d   = in_fire || (s1_full_q && !s1_advance);
      s2_full_d   = s1_move || (s2_full_q && !sel_ready);
   end

   // Stage 1: clamp illegal shifts to 0, then mirror for the inverse permutation.
   always_comb begin
      in_range = shift_factor < ZS;
      e_raw    = in_range ? shift_factor : '0;
      s1_e_d   = (shift_inv && (e_raw != '0)) ? (ZS - e_raw) : e_raw;
   end

   // Stage 2: right shift is the complement; merge picks left network for the low Z-e lanes.
   always_comb begin
      right_d   = (s1_e_q == '0) ? '0 : (ZS - s1_e_q);
      merge_lim = Z - 32'(s1_e_q);
      merge_d   = '0;
      for (int unsigned i = 0; i < Z - 1; i++) begin
         merge_d[i] = (i < merge_lim);
      end
   end

   // Schedule position advances as each word leaves; a missing shift_last is flagged and wraps.
   always_comb begin
      col_d   = col_q;
      layer_d = layer_q;
      err_d   = err_q || (in_fire && !in_range);
      if (out_fire) begin
         if (layer_end_q) begin
            col_d   = '0;
            layer_d = layer_q + LAYER_W'(1);
         end else if (col_q == COL_LAST) begin
            col_d = '0;
            err_d = 1'b1;
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         s1_full_q   <= 1'b0;
         s1_e_q      <= '0;
         s1_last_q   <= 1'b0;
         s2_full_q   <= 1'b0;
         left_q      <= '0;
         right_q     <= '0;
         merge_q     <= '0;
         layer_end_q <= 1'b0;
         col_q       <= '0;
         layer_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         s1_full_q <= s1_full_d;
         s2_full_q <= s2_full_d;
         col_q     <= col_d;
         layer_q   <= layer_d;
         err_q     <= err_d;
         if (in_fire) begin
            s1_e_q    <= s1_e_d;
            s1_last_q <= shift_last;
         end
         if (s1_move) begin
            left_q      <= s1_e_q;
            right_q     <= right_d;
            merge_q     <= merge_d;
            layer_end_q <= s1_last_q;
         end
      end
   end

   assign sel_valid = s2_full_q;
   assign left_sel  = left_q;
   assign right_sel = right_q;
   assign merge_sel = merge_q;
   assign layer_end = layer_end_q;
   assign col_idx   = col_q;
   assign layer_cnt = layer_q;
   assign err_range = err_q;

endmodule

// File: tb/tb_qsn_ctrl_85b.sv
// Scoreboard bench for qsn_ctrl_85b: expected select words queued at input handshake, checked at output.
module tb_qsn_ctrl_85b;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        shift_valid = 1'b0;
   logic        shift_ready;
   logic [6:0]  shift_factor = '0;
   logic        shift_inv = 1'b0;
   logic        shift_last = 1'b0;
   logic        sel_valid;
   logic        sel_ready = 1'b1;
   logic [6:0]  left_sel, right_sel;
   logic [83:0] merge_sel;
   logic [2:0]  col_idx;
   logic        layer_end;
   logic [3:0]  layer_cnt;
   logic        err_range;

   qsn_ctrl_85b dut (
      .sys_clk(sys_clk), .rst(rst),
      .shift_valid(shift_valid), .shift_ready(shift_ready),
      .shift_factor(shift_factor), .shift_inv(shift_inv), .shift_last(shift_last),
      .sel_valid(sel_valid), .sel_ready(sel_ready),
      .left_sel(left_sel), .right_sel(right_sel), .merge_sel(merge_sel),
      .col_idx(col_idx), .layer_end(layer_end), .layer_cnt(layer_cnt),
      .err_range(err_range)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [6:0]  l;
      logic [6:0]  r;
      logic [83:0] m;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   col_m   = 0;
   int   lcnt_m  = 0;
   logic err_m   = 1'b0;
   int   rdy_mode = 0;
   int   rdy_ph   = 0;
   bit   rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t ref_model(input int s, input bit inv, input bit last);
      exp_t x;
      int   e;
      e = (s >= 85) ? 0 : s;
      if (inv && e != 0) e = 85 - e;
      x.l    = 7'(e);
      x.r    = (e == 0) ? 7'd0 : 7'(85 - e);
      x.last = last;
      for (int i = 0; i < 84; i++) x.m[i] = (i < 85 - e);
      return x;
   endfunction

   // Output monitor: every valid word must match the head of the scoreboard, stalled or not.
   always @(negedge sys_clk) begin
      if (!rst) begin
         if (sel_valid) begin
            if (sb.size() == 0) begin
               check_eq("spurious_valid", 128'(sb.size()), 128'(1));
            end else begin
               check_eq("left_sel",  128'(left_sel),  128'(sb[0].l));
               check_eq("right_sel", 128'(right_sel), 128'(sb[0].r));
               check_eq("merge_sel", 128'(merge_sel), 128'(sb[0].m));
               check_eq("layer_end", 128'(layer_end), 128'(sb[0].last));
               check_eq("col_idx",   128'(col_idx),   128'(col_m));
               check_eq("layer_cnt", 128'(layer_cnt), 128'(lcnt_m));
               if (sel_ready) begin
                  if (sb[0].last) begin
                     col_m  = 0;
                     lcnt_m = (lcnt_m + 1) % 16;
                  end else if (col_m == 7) begin
                     col_m = 0;
                     err_m = 1'b1;
                  end else begin
                     col_m++;
                  end
                  void'(sb.pop_front());
               end
            end
         end
         if (!sel_valid || sel_ready) check_eq("shift_ready_open", 128'(shift_ready), 128'(1));
      end
   end

   always @(posedge sys_clk) begin
      #1;
      if (rdy_mode == 1) begin
         sel_ready = rdy_pat[rdy_ph];
         rdy_ph    = (rdy_ph + 1) % 4;
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      shift_valid = 1'b0;
      tick();
      sb.delete();
      col_m = 0; lcnt_m = 0; err_m = 1'b0;
      @(negedge sys_clk);
      check_eq("rst_valid", 128'(sel_valid), 128'(0));
      check_eq("rst_left",  128'(left_sel),  128'(0));
      check_eq("rst_right", 128'(right_sel), 128'(0));
      check_eq("rst_merge", 128'(merge_sel), 128'(0));
      check_eq("rst_col",   128'(col_idx),   128'(0));
      check_eq("rst_layer", 128'(layer_cnt), 128'(0));
      check_eq("rst_err",   128'(err_range), 128'(0));
      tick();
      rst = 1'b0;
      tick();
      check_eq("rst_ready", 128'(shift_ready), 128'(1));
   endtask

   task automatic send(input int s, input bit inv, input bit last);
      bit fired = 1'b0;
      shift_valid  = 1'b1;
      shift_factor = 7'(s);
      shift_inv    = inv;
      shift_last   = last;
      for (int k = 0; k < 200 && !fired; k++) begin
         @(negedge sys_clk);
         if (shift_ready) begin
            fired = 1'b1;
            sb.push_back(ref_model(s, inv, last));
            if (s >= 85) err_m = 1'b1;
         end
         tick();
      end
      shift_valid = 1'b0;
      check_eq("send_accept", 128'(fired), 128'(1));
   endtask

   task automatic drain();
      for (int k = 0; k < 500 && sb.size() != 0; k++) tick();
      check_eq("drain_empty", 128'(sb.size()), 128'(0));
      tick();
   endtask

   task automatic check_latency(input string tag);
      @(negedge sys_clk);
      check_eq({tag, "_early"}, 128'(sel_valid), 128'(0));
      @(negedge sys_clk);
      check_eq({tag, "_valid"}, 128'(sel_valid), 128'(1));
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();

      // Zero shift and two-cycle latency
      send(0, 1'b0, 1'b0);
      check_latency("lat_s0");
      check_eq("s0_merge_ones", 128'(merge_sel), 128'({84{1'b1}}));
      drain();

      // Forward and inverse of s=10
      send(10, 1'b0, 1'b0);
      send(10, 1'b1, 1'b0);
      drain();

      // Full layer burst, no backpressure
      do_reset();
      for (int i = 1; i <= 8; i++) send(i, 1'b0, i == 8);
      drain();
      check_eq("burst_layer_cnt", 128'(layer_cnt), 128'(1));
      check_eq("burst_col_idx",   128'(col_idx),   128'(0));

      // Same burst with sel_ready toggling 1,0,0,1
      rdy_ph = 0;
      rdy_mode = 1;
      for (int i = 1; i <= 8; i++) send(i, i[0], i == 8);
      drain();
      rdy_mode = 0;
      sel_ready = 1'b1;
      tick();
      check_eq("stall_layer_cnt", 128'(layer_cnt), 128'(2));

      // Nine columns with no shift_last: column wraps and flags an error, layer count holds
      for (int i = 0; i < 9; i++) send(20 + i, 1'b0, 1'b0);
      drain();
      check_eq("wrap_err",   128'(err_range), 128'(err_m));
      check_eq("wrap_err1",  128'(err_range), 128'(1));
      check_eq("wrap_layer", 128'(layer_cnt), 128'(2));
      check_eq("wrap_col",   128'(col_idx),   128'(col_m));

      // Out-of-range shift factors
      do_reset();
      send(85, 1'b0, 1'b0);
      send(127, 1'b1, 1'b0);
      drain();
      check_eq("range_err", 128'(err_range), 128'(1));
      repeat (5) tick();
      check_eq("range_err_sticky", 128'(err_range), 128'(1));

      // Reset with both stages full flushes everything
      sel_ready = 1'b0;
      send(3, 1'b0, 1'b0);
      send(4, 1'b0, 1'b0);
      @(negedge sys_clk);
      check_eq("both_full_ready", 128'(shift_ready), 128'(0));
      tick();
      rst = 1'b1;
      tick();
      sb.delete();
      col_m = 0; lcnt_m = 0; err_m = 1'b0;
      @(negedge sys_clk);
      check_eq("flush_valid", 128'(sel_valid), 128'(0));
      check_eq("flush_col",   128'(col_idx),   128'(0));
      check_eq("flush_layer", 128'(layer_cnt), 128'(0));
      check_eq("flush_err",   128'(err_range), 128'(0));
      tick();
      rst = 1'b0;
      sel_ready = 1'b1;
      tick();
      send(20, 1'b0, 1'b1);
      check_latency("lat_post_rst");
      drain();
      check_eq("post_rst_layer", 128'(layer_cnt), 128'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
